// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and the per-operation iteration count.
package div_pkg;

    localparam int DIV_WIDTH = 25;
    localparam int DIV_ITERS = 2 * DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int iter_count(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module twos_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one restoring quotient bit per cycle, truncating toward zero.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 overflow,
    output logic                 div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int ITERS = iter_count(WIDTH);
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [DW-1:0] POS_MAX = {{(DW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MAG = {{(DW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             overflow_q, overflow_d;
    logic             dbz_q, dbz_d;

    logic [DW-1:0]    abs_dvd_s;
    logic [WIDTH-1:0] abs_dsr_s;
    logic [WIDTH+1:0] trial_s;
    logic [DW-1:0]    quo_step_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [DW-1:0]    quo_signed_s;
    logic [WIDTH-1:0] rem_signed_s;
    logic             ovf_s;

    twos_negate #(.W(DW)) u_abs_dvd (
        .in_val (dividend),
        .neg    (dividend[DW-1]),
        .out_val(abs_dvd_s)
    );

    twos_negate #(.W(WIDTH)) u_abs_dsr (
        .in_val (divisor),
        .neg    (divisor[WIDTH-1]),
        .out_val(abs_dsr_s)
    );

    twos_negate #(.W(DW)) u_sgn_quo (
        .in_val (quo_step_s),
        .neg    (sign_a_q ^ sign_b_q),
        .out_val(quo_signed_s)
    );

    twos_negate #(.W(WIDTH)) u_sgn_rem (
        .in_val (rem_step_s),
        .neg    (sign_a_q),
        .out_val(rem_signed_s)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial_s = {1'b0, rem_q, quo_q[DW-1]} - {2'b00, dsr_q};
        if (trial_s[WIDTH+1]) begin
            rem_step_s = {rem_q[WIDTH-2:0], quo_q[DW-1]};
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
        end
        quo_step_s = {quo_q[DW-2:0], ~trial_s[WIDTH+1]};
        // Magnitude check: a negative result may reach one further than a positive one.
        if (sign_a_q ^ sign_b_q) begin
            ovf_s = (quo_step_s > NEG_MAG);
        end else begin
            ovf_s = (quo_step_s > POS_MAX);
        end
    end

    // Next-state and datapath update for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_a_d = dividend[DW-1];
                    sign_b_d = divisor[WIDTH-1];
                    quo_d    = abs_dvd_s;
                    rem_d    = {WIDTH{1'b0}};
                    dsr_d    = abs_dsr_s;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d     = DONE;
                        dbz_d       = 1'b1;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend[WIDTH-1:0];
                        overflow_d  = 1'b0;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(ITERS);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                quo_d = quo_step_s;
                rem_d = rem_step_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = quo_signed_s[WIDTH-1:0];
                    remainder_d = rem_signed_s;
                    overflow_d  = ovf_s;
                    dbz_d       = 1'b0;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    quotient_d  = {WIDTH{1'b0}};
                    remainder_d = {WIDTH{1'b0}};
                    overflow_d  = 1'b0;
                    dbz_d       = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared only by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            quo_q       <= {DW{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dsr_q       <= {WIDTH{1'b0}};
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider at the default WIDTH=25.
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [49:0] dividend = 50'd0;
    logic [24:0] divisor = 25'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] quotient;
    logic [24:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_signed_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .overflow   (overflow),
        .div_by_zero(div_by_zero)
    );

    // Accept one operation, scramble the inputs while it runs, and wait for out_valid.
    task automatic start_div(input logic [49:0] a, input logic [24:0] b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        dividend = ~a;
        divisor  = ~b;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_div;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, quotient, remainder, overflow, div_by_zero} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b q=%h r=%h ovf=%b dbz=%b, want all 0",
                     out_valid, quotient, remainder, overflow, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [49:0] a_t [4];
        logic [24:0] b_t [4];
        logic [24:0] q_t [4];
        logic [24:0] r_t [4];
        int lat;
        a_t = '{50'd1000, -50'sd1000, 50'd1000, -50'sd1000};
        b_t = '{25'd7, 25'd7, -25'sd7, -25'sd7};
        q_t = '{25'd142, -25'sd142, -25'sd142, 25'd142};
        r_t = '{25'd6, -25'sd6, 25'd6, -25'sd6};
        for (int i = 0; i < 4; i++) begin
            start_div(a_t[i], b_t[i], lat);
            n_checks++;
            if (lat !== 51) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want 51", i, lat);
            end
            n_checks++;
            if ({quotient, remainder, overflow, div_by_zero} !== {q_t[i], r_t[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got q=%h r=%h ovf=%b dbz=%b, want q=%h r=%h ovf=0 dbz=0",
                         i, quotient, remainder, overflow, div_by_zero, q_t[i], r_t[i]);
            end
            finish_div();
            n_checks++;
            if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, 50'd0}) begin
                n_fail++;
                $display("FAIL basic_release[%0d]: got rdy=%b valid=%b q=%h r=%h, want rdy=1 valid=0 q=0 r=0",
                         i, in_ready, out_valid, quotient, remainder);
            end
        end
    endtask

    task automatic test_roundtrip;
        logic signed [24:0] a_t [4];
        logic signed [24:0] b_t [4];
        logic signed [49:0] aa;
        logic signed [49:0] bb;
        logic signed [49:0] prod;
        int lat;
        a_t = '{25'sd12345, -25'sd16777216, 25'sd16777215, -25'sd1};
        b_t = '{-25'sd678, 25'sd16777215, -25'sd16777216, 25'sd3};
        for (int i = 0; i < 4; i++) begin
            aa   = a_t[i];
            bb   = b_t[i];
            prod = aa * bb;
            start_div(prod, b_t[i], lat);
            n_checks++;
            if ({quotient, remainder, overflow, div_by_zero} !== {a_t[i], 25'd0, 1'b0, 1'b0} || lat !== 51) begin
                n_fail++;
                $display("FAIL roundtrip[%0d]: got q=%h r=%h ovf=%b dbz=%b lat=%0d, want q=%h r=0 ovf=0 dbz=0 lat=51",
                         i, quotient, remainder, overflow, div_by_zero, lat, a_t[i]);
            end
            finish_div();
        end
    endtask

    task automatic test_overflow;
        logic [49:0] a_t [6];
        logic [24:0] b_t [6];
        logic [24:0] q_t [6];
        logic [24:0] r_t [6];
        logic        o_t [6];
        int lat;
        a_t = '{50'h2000000000000, 50'h0000040000000, -50'sd16777216,
                50'd16777216, -50'sd16777216, 50'd1000};
        b_t = '{-25'sd1, 25'd1, 25'd1, 25'd1, -25'sd1, 25'h1000000};
        q_t = '{25'd0, 25'd0, 25'h1000000, 25'h1000000, 25'h1000000, 25'd0};
        r_t = '{25'd0, 25'd0, 25'd0, 25'd0, 25'd0, 25'd1000};
        o_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            start_div(a_t[i], b_t[i], lat);
            n_checks++;
            if ({quotient, remainder, overflow, div_by_zero} !== {q_t[i], r_t[i], o_t[i], 1'b0}) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got q=%h r=%h ovf=%b dbz=%b, want q=%h r=%h ovf=%b dbz=0",
                         i, quotient, remainder, overflow, div_by_zero, q_t[i], r_t[i], o_t[i]);
            end
            finish_div();
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        start_div(50'd5, 25'd0, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL dbz_latency: got %0d cycles, want 1", lat);
        end
        n_checks++;
        if ({quotient, remainder, overflow, div_by_zero} !== {25'h1FFFFFF, 25'd5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL dbz_result: got q=%h r=%h ovf=%b dbz=%b, want q=1ffffff r=5 ovf=0 dbz=1",
                     quotient, remainder, overflow, div_by_zero);
        end
        finish_div();
    endtask

    task automatic test_stall;
        int lat;
        int bad;
        bad = 0;
        start_div(-50'sd1000, 25'd7, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({out_valid, quotient, remainder, overflow, div_by_zero} !== {1'b1, -25'sd142, -25'sd6, 1'b0, 1'b0}) begin
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d unstable cycles, want 0", bad);
        end
        finish_div();
    endtask

    task automatic test_reset_mid_calc;
        int seen;
        dividend = 50'd1000;
        divisor  = 25'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, quotient, remainder, overflow, div_by_zero} !== 53'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b q=%h r=%h, want all 0", out_valid, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d cycles with valid or not ready, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_roundtrip();
        test_overflow();
        test_div_by_zero();
        test_stall();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 25, operand width; dividend width is 2*WIDTH.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  divider can accept operands.
REQ-007 dividend  input  2*WIDTH  signed two's-complement dividend.
REQ-008 divisor  input  WIDTH  signed two's-complement divisor.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  WIDTH  signed quotient.
REQ-012 remainder  output  WIDTH  signed remainder.
REQ-013 overflow  output  1  true quotient outside the signed WIDTH-bit range.
REQ-014 div_by_zero  output  1  divisor was zero.

Function
REQ-015 SHALL implement the three states IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept occurs when in_valid and in_ready are both 1 at a clock edge.
REQ-017 On accept, the block SHALL register abs(dividend) as 2*WIDTH unsigned, register abs(divisor) as WIDTH unsigned, and register both operand signs.
REQ-018 On accept with nonzero divisor, the next state SHALL be CALC with an iteration counter of 2*WIDTH.
REQ-019 CALC SHALL perform one restoring shift-subtract quotient bit per cycle, MSB first, for exactly 2*WIDTH cycles, then go to DONE.
REQ-020 out_valid SHALL rise 2*WIDTH+1 cycles after the accept edge (51 cycles at WIDTH=25).
REQ-021 Division SHALL truncate toward zero.
REQ-022 The quotient sign SHALL be the XOR of the operand signs.
REQ-023 The remainder sign SHALL be that of the dividend, with |remainder| < |divisor|.
REQ-024 quotient SHALL be the low WIDTH bits of the true 2*WIDTH-bit signed quotient.
REQ-025 overflow SHALL be 1 when the true quotient is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], including -2^(2*WIDTH-1) / -1.
REQ-026 On accept with divisor = 0, the block SHALL go directly to DONE with out_valid high 1 cycle after accept, div_by_zero=1, quotient all ones, remainder = dividend[WIDTH-1:0], overflow=0.
REQ-027 In DONE, out_valid SHALL be 1 and all result outputs SHALL be held stable until out_ready is 1.
REQ-028 When out_valid and out_ready are both 1 at an edge, the block SHALL return to IDLE, and in_ready SHALL be 1 in the next cycle; there is no accept in the same cycle as the result handshake.
REQ-029 in_valid SHALL be ignored outside IDLE, and operand changes during CALC SHALL not affect the result.
REQ-030 quotient, remainder, overflow and div_by_zero SHALL be 0 whenever out_valid is 0.

Reset
REQ-031 Asserting rst_n low SHALL immediately force IDLE, in_ready=1 (once released), out_valid=0 and all result outputs to 0.
REQ-032 Reset mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-033 All state and datapath registers SHALL be async-reset to 0; there SHALL be no synchronous reset path.

Structure
REQ-034 Shared package div_pkg SHALL hold WIDTH default, the state enum (IDLE, CALC, DONE) and the iteration-count constant 2*WIDTH.
REQ-035 One sub-module, twos_negate (conditional two's-complement negate, parameterised width), SHALL be used for operand abs and result sign correction.
REQ-036 Implementation SHALL be synthesizable; no "/" or "%" operators are permitted.

Verification
REQ-037 dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0, out_valid at cycle 51.
REQ-038 dividend=-1000, divisor=7 -> quotient=-142, remainder=-6; dividend=1000, divisor=-7 -> quotient=-142, remainder=6.
REQ-039 Round-trip with the 25x25 multiplier: random A,B, dividend=A*B, divisor=B≠0 -> quotient=A, remainder=0, overflow=0.
REQ-040 dividend=-2^49, divisor=-1 -> overflow=1; dividend=2^30, divisor=1 -> overflow=1.
REQ-041 divisor=0, dividend=5 -> out_valid after 1 cycle, div_by_zero=1, quotient=25'h1FFFFFF, remainder=5.
REQ-042 out_ready held low 10 cycles in DONE -> outputs stable; rst_n pulsed low at CALC cycle 20 -> out_valid stays 0, in_ready=1 after release.
